alu_iterative: RTL and testbench

//   Multi-cycle integer execute unit that consumes the 4-bit alu_op produced by ALU control.
//   ADD/SUB/SLT/SLTU/XOR/OR/AND complete in one cycle.
//   SLL/SRL/SRA use a serial shifter that moves SHIFT_STEP bits per cycle, saving area.
//   It sits between the register-read stage and writeback. Valid/ready handshakes on both sides.

---
 rtl/alu_iterative.sv | 146 ++++++++++++++
 tb/tb_alu_iterative.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Multi-cycle integer execute unit: logic/arithmetic ops finish in one cycle,
// shifts run through a serial shifter that moves SHIFT_STEP bits per cycle.
module alu_iterative #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_SLL  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b1000;
    localparam logic [3:0] OP_AND  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e          state_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] shiftReg_q;
    logic [CW-1:0]   remaining_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            outValid_q;

    logic [SHW-1:0]  shamt;
    logic            isShift;
    logic            accept;
    logic [XLEN-1:0] immResult;
    logic [CW-1:0]   stepAmt;
    logic [XLEN-1:0] shiftReg_d;
    logic [CW-1:0]   remaining_d;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = outValid_q;
    assign result    = result_q;
    assign zero      = zero_q;

    // Single-cycle datapath; a shift only lands here when its amount is zero.
    always_comb begin
        shamt     = op_b[SHW-1:0];
        isShift   = (alu_op == OP_SLL) | (alu_op == OP_SRL) | (alu_op == OP_SRA);
        immResult = '0;
        case (alu_op)
            OP_ADD:  immResult = op_a + op_b;
            OP_SUB:  immResult = op_a - op_b;
            OP_SLT:  immResult = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU: immResult = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:  immResult = op_a ^ op_b;
            OP_OR:   immResult = op_a | op_b;
            OP_AND:  immResult = op_a & op_b;
            OP_SLL, OP_SRL, OP_SRA: immResult = op_a;
            default: immResult = '0;
        endcase
    end

    // One serial shift step; the last step may be shorter than SHIFT_STEP.
    always_comb begin
        stepAmt    = (remaining_q < STEP) ? remaining_q : STEP;
        shiftReg_d = shiftReg_q;
        case (op_q)
            OP_SLL:  shiftReg_d = shiftReg_q << stepAmt;
            OP_SRL:  shiftReg_d = shiftReg_q >> stepAmt;
            OP_SRA:  shiftReg_d = $signed(shiftReg_q) >>> stepAmt;
            default: shiftReg_d = shiftReg_q;
        endcase
        remaining_d = remaining_q - stepAmt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            shiftReg_q  <= '0;
            remaining_q <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            outValid_q  <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            outValid_q  <= 1'b0;
        end else if (accept) begin
            op_q <= alu_op;
            if (isShift && (shamt != '0)) begin
                shiftReg_q  <= op_a;
                remaining_q <= {1'b0, shamt};
                outValid_q  <= 1'b0;
                state_q     <= SHIFT;
            end else begin
                result_q   <= immResult;
                zero_q     <= (immResult == '0);
                outValid_q <= 1'b1;
                state_q    <= DONE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                end
                SHIFT: begin
                    shiftReg_q  <= shiftReg_d;
                    remaining_q <= remaining_d;
                    if (remaining_d == '0) begin
                        result_q   <= shiftReg_d;
                        zero_q     <= (shiftReg_d == '0);
                        outValid_q <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        outValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed scenarios plus random ops
// checked against a whole-operation arithmetic reference model.
module tb_alu_iterative;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int errors;
    int checks;

    alu_iterative #(.XLEN(32), .SHIFT_STEP(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: the whole operation in one step, straight from the opcode table.
    function automatic logic [31:0] refResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a << b[4:0];
            4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4: r = (a < b) ? 32'd1 : 32'd0;
            4'd5: r = a ^ b;
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: r = a | b;
            4'd9: r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int refLatency(input logic [3:0] op, input logic [31:0] b);
        if ((op == 4'd2 || op == 4'd6 || op == 4'd7) && b[4:0] != 5'd0)
            return 1 + int'(b[4:0]);
        return 1;
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers one op from IDLE, then scrambles the inputs and waits for out_valid.
    task automatic issueOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [31:0] res, output logic z,
                           output logic readySeen);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        alu_op    = 4'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat       = 1;
        readySeen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) readySeen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        res = result;
        z   = zero;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idleCycles(2);
        checks++;
        if ({out_valid, result, zero, in_ready} !== {1'b0, 32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state: got valid=%b result=%h zero=%b ready=%b, expected 0/00000000/1/1",
                     out_valid, result, zero, in_ready);
        end
        reset_n = 1'b1;
        idleCycles(1);
    endtask

    task automatic test_add_overflow();
        int lat; logic [31:0] res; logic z; logic rs;
        issueOp(4'd0, 32'h7FFF_FFFF, 32'd1, lat, res, z, rs);
        checks++;
        if ({lat, res, z} !== {32'd1, 32'h8000_0000, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_overflow: got lat=%0d result=%h zero=%b, expected 1/80000000/0", lat, res, z);
        end
        idleCycles(1);
    endtask

    task automatic test_back_to_back();
        alu_op = 4'd1; op_a = 32'd5; op_b = 32'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_op = 4'd4; op_a = 32'd1; op_b = 32'd3;
        checks++;
        if ({out_valid, result, zero, in_ready} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL b2b_sub: got valid=%b result=%h zero=%b ready=%b, expected 1/00000000/1/1",
                     out_valid, result, zero, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, result, zero} !== {1'b1, 32'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_sltu: got valid=%b result=%h zero=%b, expected 1/00000001/0", out_valid, result, zero);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_drain: got valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_sra_long();
        int lat; logic [31:0] res; logic z; logic rs;
        issueOp(4'd7, 32'h8000_0000, 32'd31, lat, res, z, rs);
        checks++;
        if ({lat, res, rs} !== {32'd32, 32'hFFFF_FFFF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL sra_31: got lat=%0d result=%h readyInShift=%b, expected 32/ffffffff/0", lat, res, rs);
        end
        idleCycles(1);
    endtask

    task automatic test_corner_ops();
        int lat; logic [31:0] res; logic z; logic rs;
        logic [31:0] a;
        a = $urandom | 32'h1;
        issueOp(4'd2, a, 32'hFFFF_FFE0, lat, res, z, rs);
        checks++;
        if ({lat, res} !== {32'd1, a}) begin
            errors++;
            $display("[TB] FAIL sll_shamt0: got lat=%0d result=%h, expected 1/%h", lat, res, a);
        end
        idleCycles(1);
        issueOp(4'd3, 32'hFFFF_FFFF, 32'd1, lat, res, z, rs);
        checks++;
        if ({lat, res, z} !== {32'd1, 32'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL slt_neg: got lat=%0d result=%h zero=%b, expected 1/00000001/0", lat, res, z);
        end
        idleCycles(1);
        issueOp(4'b1100, 32'h1234_5678, 32'h0000_00FF, lat, res, z, rs);
        checks++;
        if ({lat, res, z} !== {32'd1, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reserved_op: got lat=%0d result=%h zero=%b, expected 1/00000000/1", lat, res, z);
        end
        idleCycles(1);
    endtask

    task automatic test_hold();
        int lat; logic [31:0] res; logic z; logic rs;
        logic [31:0] a, b, exp;
        a = $urandom; b = $urandom;
        exp = a ^ b;
        out_ready = 1'b0;
        issueOp(4'd5, a, b, lat, res, z, rs);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            alu_op   = 4'd0;
            op_a     = $urandom;
            checks++;
            if ({out_valid, result, in_ready} !== {1'b1, exp, 1'b0}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got valid=%b result=%h ready=%b, expected 1/%h/0",
                         i, out_valid, result, in_ready, exp);
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL hold_release: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_flush();
        int seen;
        alu_op = 4'd6; op_a = $urandom; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idleCycles(2);
        flush = 1'b1; in_valid = 1'b1; alu_op = 4'd0; op_a = 32'd1; op_b = 32'd2;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL flush_idle: got valid=%b ready=%b, expected 0/1", out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL flush_no_output: got %0d valid cycles, expected 0", seen);
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        alu_op = 4'd7; op_a = 32'hF000_000F; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idleCycles(5);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checks++;
        if ({out_valid, result, zero} !== {1'b0, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_mid_shift: got valid=%b result=%h zero=%b, expected 0/00000000/1",
                     out_valid, result, zero);
        end
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL reset_no_output: got %0d valid cycles, expected 0", seen);
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] res; logic z; logic rs;
        logic [3:0]  op;
        logic [31:0] a, b, exp;
        int expLat;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if (i % 8 == 0) b[4:0] = 5'd0;
            if (i % 5 == 1) b = a;
            exp    = refResult(op, a, b);
            expLat = refLatency(op, b);
            issueOp(op, a, b, lat, res, z, rs);
            checks++;
            if (res !== exp || z !== (exp == 32'd0) || lat != expLat) begin
                errors++;
                $display("[TB] FAIL random_%0d op=%h a=%h b=%h: got result=%h zero=%b lat=%0d, expected %h/%b/%0d",
                         i, op, a, b, res, z, lat, exp, (exp == 32'd0), expLat);
            end
            if (i % 3 == 0) idleCycles(1);
        end
    endtask

    initial begin
        clk       = 1'b0;
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        errors    = 0;
        checks    = 0;
        #1;
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_sra_long();
        test_corner_ops();
        test_hold();
        test_flush();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
